mobius_stream: RTL and testbench

- Parametrised, handshaked successor of the clocked Möbius-transform core over GF(2).
- Accepts one N-bit truth-table vector (N = 2**LOG2_N) on a valid/ready input port.
- Iterates butterfly+perfect-shuffle rounds, ROUNDS_PER_CYCLE rounds per clock, and presents the result on a valid/ready output port.
- Adds selectable direction (subset/superset transform), explicit start/finish control, reset, back-to-back operation and output backpressure, none of which the single-shot core has.

---
 rtl/mobius_stream.sv | 164 ++++++++++++++++
 tb/tb_mobius_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mobius_stream.sv
// mobius_stream
//   Handshaked Moebius transform over GF(2) on an N-bit truth table
//   (N = 2**LOG2_N). One vector is accepted, LOG2_N butterfly+shuffle rounds
//   are applied (ROUNDS_PER_CYCLE per clock), and the result is offered on
//   the output port until consumed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input vector offered
//   in_ready   block accepts a vector this cycle
//   in_data    [0:N-1] truth table, bit 0 = index 0 (leftmost)
//   in_mode    0 = subset (ANF) transform, 1 = superset (dual) transform
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_data   [0:N-1] transformed vector (registered)
//   busy       high while rounds are being computed
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_valid may be offered at any time; in_ready is 1 in IDLE,
// 0 in RUN, and follows out_ready in HOLD so a new vector can be taken in
// the same cycle the result leaves. out_valid holds with stable out_data
// until out_ready is seen.

module mobius_stream #(
   parameter int LOG2_N           = 6,
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [0:(2**LOG2_N)-1] in_data,
   input  logic            in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [0:(2**LOG2_N)-1] out_data,
   output logic            busy
);

   localparam int N  = 2**LOG2_N;
   localparam int CW = $clog2(LOG2_N + 1);
   // Guarded divisor so the modulo below is legal even for illegal values.
   localparam int U_SAFE = (ROUNDS_PER_CYCLE < 1) ? 1 : ROUNDS_PER_CYCLE;

   if (LOG2_N < 1 || ROUNDS_PER_CYCLE < 1 || (LOG2_N % U_SAFE) != 0) begin : g_bad_params
      $error("mobius_stream: ROUNDS_PER_CYCLE must be >= 1 and divide LOG2_N");
   end

   localparam logic [CW-1:0] CNT_STEP = CW'(U_SAFE);
   localparam logic [CW-1:0] CNT_DONE = CW'(LOG2_N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [0:N-1]    data_q, data_d;
   logic            mode_q, mode_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [0:N-1]    run_data;
   logic [CW-1:0]   cnt_next;

   // One round: butterfly across the two halves, then perfect shuffle.
   // The shuffle rotates the index bits, so every index bit passes through
   // the butterfly position exactly once over LOG2_N rounds.
   function automatic logic [0:N-1] mobius_round(input logic [0:N-1] x, input logic m);
      logic [0:N-1] y;
      y = '0;
      for (int i = 0; i < N/2; i++) begin
         y[2*i]   = m ? (x[i] ^ x[i+N/2]) : x[i];
         y[2*i+1] = m ? x[i+N/2]          : (x[i+N/2] ^ x[i]);
      end
      return y;
   endfunction

   // Unrolled chain of rounds applied in one RUN clock.
   always_comb begin
      logic [0:N-1] chain;
      chain = data_q;
      for (int r = 0; r < U_SAFE; r++) begin
         chain = mobius_round(chain, mode_q);
      end
      run_data = chain;
      cnt_next = cnt_q + CNT_STEP;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               data_d  = in_data;
               mode_d  = in_mode;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            data_d = run_data;
            cnt_d  = cnt_next;
            if (cnt_next == CNT_DONE) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               if (in_valid && in_ready) begin
                  // Result leaves and the next vector enters on the same edge.
                  data_d  = in_data;
                  mode_d  = in_mode;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_RUN:  busy     = 1'b1;
         S_HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   assign out_data = data_q;

endmodule

// File: tb/tb_mobius_stream.sv
// Bench for mobius_stream: directed cases on LOG2_N=3 (U=1 and U=3) and
// randomized streams on LOG2_N=6 (U=1 and U=3) against a subset/superset
// sum reference model.

module tb_mobius_stream;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: out[u] = XOR of in[v] over v subset of u (mode 0) or
   // v superset of u (mode 1). Index v sits at position v of x.
   function automatic logic [0:63] ref_mobius(input logic [0:63] x, input int n, input logic m);
      logic [0:63] r;
      int nn;
      nn = 1 << n;
      r  = '0;
      for (int u = 0; u < nn; u++) begin
         logic acc;
         acc = 1'b0;
         for (int v = 0; v < nn; v++) begin
            if (m ? ((u & ~v) == 0) : ((v & ~u) == 0)) acc ^= x[v];
         end
         r[u] = acc;
      end
      return r;
   endfunction

   // ---------------- LOG2_N=3, U=1 ----------------
   logic       a_rst_n, a_iv, a_ir, a_md, a_ov, a_or, a_busy;
   logic [0:7] a_id, a_od;

   mobius_stream #(.LOG2_N(3), .ROUNDS_PER_CYCLE(1)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .in_valid(a_iv), .in_ready(a_ir),
      .in_data(a_id), .in_mode(a_md), .out_valid(a_ov), .out_ready(a_or),
      .out_data(a_od), .busy(a_busy)
   );

   // ---------------- LOG2_N=3, U=3 ----------------
   logic       d_rst_n, d_iv, d_ir, d_md, d_ov, d_or, d_busy;
   logic [0:7] d_id, d_od;

   mobius_stream #(.LOG2_N(3), .ROUNDS_PER_CYCLE(3)) dut_d (
      .clk(clk), .rst_n(d_rst_n), .in_valid(d_iv), .in_ready(d_ir),
      .in_data(d_id), .in_mode(d_md), .out_valid(d_ov), .out_ready(d_or),
      .out_data(d_od), .busy(d_busy)
   );

   // ---------------- LOG2_N=6, random streams ----------------
   localparam int NV = 200;

   for (genvar g = 0; g < 2; g++) begin : g_rand
      localparam int U = (g == 0) ? 1 : 3;
      logic        iv, ir, md, ov, orr, bz, took;
      logic [0:63] id, od;
      logic [63:0] exp_q[$];
      int          sent, got;
      bit          done;

      mobius_stream #(.LOG2_N(6), .ROUNDS_PER_CYCLE(U)) dut (
         .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
         .in_data(id), .in_mode(md), .out_valid(ov), .out_ready(orr),
         .out_data(od), .busy(bz)
      );

      initial begin
         iv = 1'b0; orr = 1'b0; id = '0; md = 1'b0;
         sent = 0; got = 0; done = 1'b0; took = 1'b0;
         #1;
         wait (rst_n === 1'b1);
         for (int c = 0; c < 20000 && got < NV; c++) begin
            @(posedge clk); #1;
            if (!iv || took) begin
               if (sent < NV && $urandom_range(0, 9) < 6) begin
                  iv = 1'b1;
               end else begin
                  iv = 1'b0;
               end
               id = {$urandom, $urandom};
               md = 1'($urandom_range(0, 1));
            end
            orr = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            took = iv && ir;
            if (took) begin
               exp_q.push_back(ref_mobius(id, 6, md));
               sent++;
            end
            if (ov && orr) begin
               if (exp_q.size() == 0) check_eq($sformatf("rnd%0d_spurious", g), 64'd1, 64'd0);
               else check_eq($sformatf("rnd%0d_data", g), od, exp_q.pop_front());
               got++;
            end
         end
         check_eq($sformatf("rnd%0d_count", g), 64'(got), 64'(NV));
         check_eq($sformatf("rnd%0d_leftover", g), 64'(exp_q.size()), 64'd0);
         done = 1'b1;
      end
   end

   // Accept one vector on dut_a, measure latency and busy span, consume it.
   task automatic a_xfer(input logic [0:7] d, input logic m, input logic [0:7] exp, input string tag);
      int lat, bcnt;
      @(posedge clk); #1;
      a_iv = 1'b1; a_id = d; a_md = m;
      @(negedge clk);
      check_eq({tag, "_ready"}, 64'(a_ir), 64'd1);
      @(posedge clk); #1;
      a_iv = 1'b0; a_id = 8'($urandom); a_md = 1'($urandom_range(0, 1));
      lat = 0; bcnt = 0;
      while (!a_ov && lat < 20) begin
         if (a_busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, "_lat"}, 64'(lat), 64'd3);
      check_eq({tag, "_busy"}, 64'(bcnt), 64'd3);
      check_eq({tag, "_data"}, a_od, exp);
      a_or = 1'b1;
      @(posedge clk); #1;
      a_or = 1'b0;
      check_eq({tag, "_ovdrop"}, 64'(a_ov), 64'd0);
   endtask

   initial begin
      int lat;
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; a_rst_n = 1'b0; d_rst_n = 1'b0;
      a_iv = 1'b0; a_id = '0; a_md = 1'b0; a_or = 1'b0;
      d_iv = 1'b1; d_id = 8'hC0; d_md = 1'b0; d_or = 1'b0;
      #23;
      rst_n = 1'b1; a_rst_n = 1'b1;
      #1;
      check_eq("rst_ov", 64'(a_ov), 64'd0);
      check_eq("rst_busy", 64'(a_busy), 64'd0);
      check_eq("rst_data", a_od, 64'h0);
      check_eq("rst_ready", 64'(a_ir), 64'd1);

      // out_ready with nothing to deliver.
      a_or = 1'b1;
      @(posedge clk); #1;
      check_eq("idle_or_ov", 64'(a_ov), 64'd0);
      a_or = 1'b0;

      a_xfer(8'h80, 1'b0, 8'hFF, "t1");
      a_xfer(8'hC0, 1'b0, 8'hAA, "t2a");
      a_xfer(8'h80, 1'b1, 8'h80, "t2b");
      a_xfer(8'h01, 1'b1, 8'hFF, "t2c");
      a_xfer(8'hAA, 1'b0, 8'hC0, "t2d");

      // Backpressure, then zero-bubble back-to-back accept.
      @(posedge clk); #1;
      a_iv = 1'b1; a_id = 8'hC0; a_md = 1'b0;
      @(posedge clk); #1;
      a_iv = 1'b0;
      for (int k = 0; k < 20 && !a_ov; k++) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < 10; k++) begin
         a_iv = 1'b1; a_id = 8'($urandom); a_md = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq("bp_ov", 64'(a_ov), 64'd1);
         check_eq("bp_data", a_od, 64'hAA);
         check_eq("bp_ready", 64'(a_ir), 64'd0);
         @(posedge clk); #1;
      end
      a_or = 1'b1; a_iv = 1'b1; a_id = 8'h01; a_md = 1'b1;
      @(negedge clk);
      check_eq("b2b_ready", 64'(a_ir), 64'd1);
      @(posedge clk); #1;
      a_or = 1'b0; a_iv = 1'b0;
      check_eq("b2b_ov", 64'(a_ov), 64'd0);
      check_eq("b2b_busy", 64'(a_busy), 64'd1);
      lat = 0;
      while (!a_ov && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("b2b_lat", 64'(lat), 64'd3);
      check_eq("b2b_data", a_od, 64'hFF);
      a_or = 1'b1;
      @(posedge clk); #1;
      a_or = 1'b0;

      // Reset one clock into RUN.
      @(posedge clk); #1;
      a_iv = 1'b1; a_id = 8'h80; a_md = 1'b0;
      @(posedge clk); #1;
      a_iv = 1'b0;
      @(posedge clk); #2;
      a_rst_n = 1'b0;
      #1;
      check_eq("arst_ov", 64'(a_ov), 64'd0);
      check_eq("arst_busy", 64'(a_busy), 64'd0);
      check_eq("arst_data", a_od, 64'h0);
      #2;
      a_rst_n = 1'b1;
      a_xfer(8'h01, 1'b0, 8'h01, "t5");

      // U=LOG2_N: accept on the first edge after reset release, one-clock RUN.
      @(posedge clk); #3;
      d_rst_n = 1'b1;
      @(posedge clk); #1;
      d_iv = 1'b0;
      check_eq("u3_busy", 64'(d_busy), 64'd1);
      check_eq("u3_ov0", 64'(d_ov), 64'd0);
      @(posedge clk); #1;
      check_eq("u3_ov1", 64'(d_ov), 64'd1);
      check_eq("u3_data", d_od, 64'hAA);
      check_eq("u3_idle", 64'(d_busy), 64'd0);
      d_or = 1'b1;
      @(posedge clk); #1;
      d_or = 1'b0;
      check_eq("u3_ovdrop", 64'(d_ov), 64'd0);

      for (int c = 0; c < 60000 && !(g_rand[0].done && g_rand[1].done); c++) begin
         @(posedge clk);
      end
      check_eq("rnd0_done", 64'(g_rand[0].done), 64'd1);
      check_eq("rnd1_done", 64'(g_rand[1].done), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
